// File: rtl/ps2_key_pkg.sv
// Shared scancodes and defaults for the PS/2 key tracker.
// Latency: n/a (constants only). Backpressure: n/a.
// Optional repeat feature: PS2_KEY_TRACKER_REPEAT_EN.
package ps2_key_pkg;

    localparam logic [7:0] KEY_Q = 8'h15;
    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_E = 8'h24;
    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_D = 8'h23;

    // Channel 0 sits in the low byte.
    localparam logic [47:0] KEY_CODES_DEFAULT = {KEY_D, KEY_S, KEY_A, KEY_E, KEY_W, KEY_Q};

    localparam int HOLD_CYCLES_DEFAULT   = 25_000_000;
    localparam int REPEAT_CYCLES_DEFAULT = 5_000_000;

endpackage

// File: rtl/ps2_key_channel.sv
// One tracked key: held flag, press/release pulses, hold counter, optional repeat (PS2_KEY_TRACKER_REPEAT_EN).
// Latency: outputs register one cycle after make_evt/break_evt.
// Backpressure: none; events are one-cycle strobes consumed unconditionally.
module ps2_key_channel
    import ps2_key_pkg::*;
#(
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEFAULT,
    parameter int CNT_W         = 25
`ifdef PS2_KEY_TRACKER_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT
`endif
) (
    input  logic clk,
    input  logic resetn,
    input  logic make_evt,
    input  logic break_evt,
    output logic key_held,
    output logic key_pressed,
    output logic key_released,
    output logic hold_long
`ifdef PS2_KEY_TRACKER_REPEAT_EN
    ,
    output logic key_repeat
`endif
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

    logic             held_nxt;
    logic             hold_long_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Typematic makes leave held_nxt at 1, so the counter keeps running.
    always_comb begin
        held_nxt = key_held;
        if (make_evt)
            held_nxt = 1'b1;
        else if (break_evt)
            held_nxt = 1'b0;

        cnt_nxt = cnt;
        if (!held_nxt)
            cnt_nxt = '0;
        else if (key_held && cnt != HOLD_MAX)
            cnt_nxt = cnt + 1'b1;

        hold_long_nxt = held_nxt && (cnt_nxt == HOLD_MAX);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_held     <= 1'b0;
            key_pressed  <= 1'b0;
            key_released <= 1'b0;
            hold_long    <= 1'b0;
            cnt          <= '0;
        end else begin
            key_held     <= held_nxt;
            key_pressed  <= make_evt & ~key_held;
            key_released <= break_evt & key_held;
            hold_long    <= hold_long_nxt;
            cnt          <= cnt_nxt;
        end
    end

`ifdef PS2_KEY_TRACKER_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rpt_cnt;
    logic             rpt_nxt;

    // First pulse coincides with the hold_long rise, then one per period.
    assign rpt_nxt = hold_long_nxt && (!hold_long || rpt_cnt == RPT_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rpt_cnt    <= '0;
            key_repeat <= 1'b0;
        end else begin
            key_repeat <= rpt_nxt;
            rpt_cnt    <= (!hold_long_nxt || rpt_nxt) ? '0 : rpt_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/ps2_key_tracker.sv
// Synchronises the keyboard event strobe and maps set-2 scancodes to per-key state (repeat: PS2_KEY_TRACKER_REPEAT_EN).
// Latency: outputs update after the 4th clk edge sampling valid high (E3).
// Backpressure: none; valid must stay high >=3 cycles and low >=3 cycles between events.
module ps2_key_tracker
    import ps2_key_pkg::*;
#(
    parameter int                  N_KEYS        = 6,
    parameter logic [N_KEYS*8-1:0] KEY_CODES     = KEY_CODES_DEFAULT,
    parameter int                  HOLD_CYCLES   = HOLD_CYCLES_DEFAULT,
    parameter int                  CNT_W         = 25
`ifdef PS2_KEY_TRACKER_REPEAT_EN
    ,
    parameter int                  REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT
`endif
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              valid,
    input  logic              makeBreak,
    input  logic [7:0]        outCode,
    output logic [N_KEYS-1:0] key_held,
    output logic [N_KEYS-1:0] key_pressed,
    output logic [N_KEYS-1:0] key_released,
    output logic [N_KEYS-1:0] hold_long,
    output logic              unknown_code
`ifdef PS2_KEY_TRACKER_REPEAT_EN
    ,
    output logic [N_KEYS-1:0] key_repeat
`endif
);

    logic              s1, s2, s3;
    logic              evt_vld;
    logic              evt_make;
    logic [7:0]        evt_code;
    logic [N_KEYS-1:0] match;

    // outCode/makeBreak are quasi-static while valid is high, so sampling
    // them on the synchronised edge is safe without extra stages.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            evt_vld      <= 1'b0;
            evt_make     <= 1'b0;
            evt_code     <= '0;
            unknown_code <= 1'b0;
        end else begin
            s1           <= valid;
            s2           <= s1;
            s3           <= s2;
            evt_vld      <= s2 & ~s3;
            unknown_code <= evt_vld & ~|match;
            if (s2 & ~s3) begin
                evt_make <= makeBreak;
                evt_code <= outCode;
            end
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        assign match[i] = evt_vld && (evt_code == KEY_CODES[8*i +: 8]);

        ps2_key_channel #(
            .HOLD_CYCLES   (HOLD_CYCLES),
            .CNT_W         (CNT_W)
`ifdef PS2_KEY_TRACKER_REPEAT_EN
            ,
            .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
        ) u_ch (
            .clk          (clk),
            .resetn       (resetn),
            .make_evt     (match[i] & evt_make),
            .break_evt    (match[i] & ~evt_make),
            .key_held     (key_held[i]),
            .key_pressed  (key_pressed[i]),
            .key_released (key_released[i]),
            .hold_long    (hold_long[i])
`ifdef PS2_KEY_TRACKER_REPEAT_EN
            ,
            .key_repeat   (key_repeat[i])
`endif
        );
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker; covers repeat output when PS2_KEY_TRACKER_REPEAT_EN is defined.
module tb_ps2_key_tracker;

    localparam int N    = 6;
    localparam int HOLD = 10;
    localparam int REP  = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       valid = 1'b0;
    logic       makeBreak = 1'b0;
    logic [7:0] outCode = 8'h00;
    logic [N-1:0] key_held, key_pressed, key_released, hold_long;
    logic         unknown_code;
`ifdef PS2_KEY_TRACKER_REPEAT_EN
    logic [N-1:0] key_repeat;
`endif

    ps2_key_tracker #(
        .N_KEYS        (N),
        .HOLD_CYCLES   (HOLD),
        .CNT_W         (8)
`ifdef PS2_KEY_TRACKER_REPEAT_EN
        ,
        .REPEAT_CYCLES (REP)
`endif
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .valid        (valid),
        .makeBreak    (makeBreak),
        .outCode      (outCode),
        .key_held     (key_held),
        .key_pressed  (key_pressed),
        .key_released (key_released),
        .hold_long    (hold_long),
        .unknown_code (unknown_code)
`ifdef PS2_KEY_TRACKER_REPEAT_EN
        ,
        .key_repeat   (key_repeat)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [5:0] held, pressed, released, hl, rep;
        logic       unk;
    } exp_t;

    exp_t        sb[$];
    logic [47:0] codes = {8'h23, 8'h1B, 8'h1C, 8'h24, 8'h1D, 8'h15};
    logic [5:0]  m_held = '0;
    int          m_since[N];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model_at(input int d);
        exp_t e;
        e.due = d; e.held = m_held; e.pressed = '0; e.released = '0;
        e.hl = '0; e.rep = '0; e.unk = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_held[i] && (d - m_since[i]) >= HOLD) begin
                e.hl[i]  = 1'b1;
                e.rep[i] = ((d - m_since[i] - HOLD) % REP) == 0;
            end
        end
        return e;
    endfunction

    // Called on a negedge; the DUT reflects the event at the negedge after E3.
    task automatic send_event(input logic [7:0] code, input logic mk);
        int         c;
        logic [5:0] match, pr, rl;
        exp_t       e;
        c = cyc;
        match = '0;
        for (int i = 0; i < N; i++) begin
            logic [7:0] k;
            k = codes[8*i +: 8];
            match[i] = (k == code);
        end
        sb.push_back(model_at(c + 3));
        pr = mk ? (match & ~m_held) : 6'b0;
        rl = mk ? 6'b0 : (match & m_held);
        m_held = (m_held | pr) & ~rl;
        for (int i = 0; i < N; i++) if (pr[i]) m_since[i] = c + 4;
        e = model_at(c + 4);
        e.pressed = pr; e.released = rl; e.unk = (match == 6'b0);
        sb.push_back(e);
        sb.push_back(model_at(c + 5));
        outCode = code; makeBreak = mk; valid = 1'b1;
        repeat (4) @(negedge clk);
        valid = 1'b0; outCode = 8'($urandom); makeBreak = 1'($urandom);
        repeat (4) @(negedge clk);
    endtask

    task automatic idle_check(input int n);
        int c;
        c = cyc;
        for (int k = 1; k <= n; k++) sb.push_back(model_at(c + k));
        repeat (n) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                if (e.due < cyc) begin
                    check("sb_late", cyc, e.due);
                end else begin
                    check("key_held", key_held, e.held);
                    check("key_pressed", key_pressed, e.pressed);
                    check("key_released", key_released, e.released);
                    check("hold_long", hold_long, e.hl);
                    check("unknown_code", unknown_code, e.unk);
`ifdef PS2_KEY_TRACKER_REPEAT_EN
                    check("key_repeat", key_repeat, e.rep);
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t;
        #1;
        check("rst_held", key_held, 0);
        check("rst_pressed", key_pressed, 0);
        check("rst_hold_long", hold_long, 0);
        check("rst_unknown", unknown_code, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        idle_check(3);

        // Single key press and release.
        send_event(8'h15, 1'b1);
        send_event(8'h15, 1'b0);

        // Typematic repeat: only the first make pulses.
        send_event(8'h1D, 1'b1);
        send_event(8'h1D, 1'b1);
        send_event(8'h1D, 1'b1);
        send_event(8'h1D, 1'b0);

        // Long hold, exact hold_long rise and repeat cadence, then release.
        send_event(8'h24, 1'b1);
        idle_check(30);
        send_event(8'h24, 1'b0);

        // Two keys together, then an unknown code.
        send_event(8'h15, 1'b1);
        send_event(8'h23, 1'b1);
        send_event(8'h5A, 1'b1);
        send_event(8'h5A, 1'b0);
        idle_check(5);

        // Asynchronous reset mid-hold.
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midrst_held", key_held, 0);
        check("midrst_hold_long", hold_long, 0);
        check("midrst_released", key_released, 0);
        m_held = '0;
        @(negedge clk);
        resetn = 1'b1;
        idle_check(4);

        // Normal operation after reset.
        send_event(8'h23, 1'b1);
        send_event(8'h23, 1'b0);

        t = 0;
        while (sb.size() > 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Synchronous, parametrised replacement for the top-level make/break keyboard decode, which currently clocks on the keyboard valid strobe.
- Maps N_KEYS configurable PS/2 set-2 scancodes to per-key held state, one-cycle press/release pulses and a long-hold flag, all in the clk domain.
- Sits between keyboard_press_driver and barbecue_hero; its key_held output drives user_press.

Parameters:
- N_KEYS, 6: number of tracked keys/channels (1..16).
- KEY_CODES, {8'h23,8'h1B,8'h1C,8'h24,8'h1D,8'h15}: packed N_KEYS*8 scancode table; channel i uses bits [8i+7:8i].
- HOLD_CYCLES, 25000000: cycles a key must stay held before hold_long asserts (0.5 s at 50 MHz).
- CNT_W, 25: width of each hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk, input, 1: system clock (CLOCK_50).
- resetn, input, 1: asynchronous active-low reset.
- valid, input, 1: event strobe from the keyboard driver; may be asynchronous to clk; treated as a level.
- makeBreak, input, 1: 1 = make, 0 = break; stable while valid is high.
- outCode, input, 8: scancode; stable while valid is high.
- key_held, output, N_KEYS: bit i = channel i currently held.
- key_pressed, output, N_KEYS: one-cycle pulse on a 0->1 transition of key_held[i].
- key_released, output, N_KEYS: one-cycle pulse on a 1->0 transition of key_held[i].
- hold_long, output, N_KEYS: bit i = channel i held for at least HOLD_CYCLES.
- unknown_code, output, 1: one-cycle pulse when an event matches no channel.

Behaviour:
- Reset (asynchronous, resetn=0):
  - All outputs, hold counters and synchroniser flops clear to 0.
  - Deassertion takes effect on the next clk edge.
- Event detection:
  - valid passes through 2 FF synchroniser stages (s1, s2), then s3.
  - An event fires when s2 & ~s3.
  - outCode and makeBreak are captured on that same cycle.
- Latency:
  - Edge E0 is the first edge sampling valid=1. The event fires in the cycle after E2.
  - Updates to key_held and pulses and unknown_code are visible after E3.
  - valid must stay high at least 3 clk cycles; a new event needs valid low for at least 3 cycles.
- Per channel i, when an event's code equals KEY_CODES[i]:
  - Make, key_held[i]=0: set key_held[i] and pulse key_pressed[i].
  - Make, key_held[i]=1 (typematic repeat): no change, no pulse, counter not reset.
  - Break, key_held[i]=1: clear key_held[i], pulse key_released[i], clear counter and hold_long[i].
  - Break, key_held[i]=0: ignored.
- Duplicate table entries: every matching channel updates identically in the same cycle.
- Unknown codes: no channel matches, so pulse unknown_code; the code is otherwise ignored. Prefix bytes (E0/F0) never reach this block.
- Hold counter, per channel:
  - Increments each cycle while key_held[i]=1.
  - Saturates at HOLD_CYCLES. hold_long[i] is registered high the cycle the counter reaches HOLD_CYCLES and stays high until release or reset.
- Multiple keys are tracked independently; any combination may be held at once.
- Reset mid-hold: everything clears; no release pulse is generated.

Optional Feature:
- Macro: PS2_KEY_TRACKER_REPEAT_EN.
- When defined:
  - Adds parameter REPEAT_CYCLES (default 5000000) and output key_repeat[N_KEYS].
  - Once hold_long[i] is high, key_repeat[i] pulses for 1 cycle immediately, then every REPEAT_CYCLES cycles while the key stays held.
  - A separate per-channel repeat counter restarts on each pulse and clears on release or reset.
- When undefined: no key_repeat port, no repeat counters; all other behaviour is identical.

Decomposition:
- Shared package ps2_key_pkg holds:
  - Scancode constants KEY_Q=8'h15, KEY_W=8'h1D, KEY_E=8'h24, KEY_A=8'h1C, KEY_S=8'h1B, KEY_D=8'h23.
  - The default KEY_CODES packing.
  - HOLD_CYCLES_DEFAULT.
- One sub-module, ps2_key_channel: a single channel's held flag, edge pulses, hold counter and optional repeat logic, instantiated N_KEYS times by a generate loop.
- The top level keeps the synchroniser, event capture, code match and unknown_code.

Test Plan:
- Reset then idle: all outputs 0. Assert resetn=0 mid-hold: key_held, hold_long 0 immediately, no key_released pulse.
- valid high 4 cycles with make 8'h15: key_held=6'b000001 after E3; key_pressed[0] high exactly 1 cycle. Matching break: key_released[0] 1-cycle pulse, key_held=0.
- Make 8'h1D repeated 3 times with no break: single key_pressed[1] pulse; key_held[1] stays 1.
- HOLD_CYCLES=10, make 8'h24: hold_long[2] rises 10 cycles after key_held[2]. Break clears both the same cycle.
- Make 8'h15 then make 8'h23: key_held=6'b100001. Event with 8'h5A: unknown_code 1-cycle pulse, key_held unchanged.
- With PS2_KEY_TRACKER_REPEAT_EN, HOLD_CYCLES=10, REPEAT_CYCLES=4, key held 30 cycles: key_repeat pulses at hold_long rise, then every 4 cycles, and stop at release.
